// File: rtl/scanline_buffer.sv
// -----------------------------------------------------------------------------
// scanline_buffer
//
// Double-buffered scanline RAM placed right after the video timing generator.
// The front bank is read out during the visible part of a line. Meanwhile an
// upstream renderer fills the next line into the back bank through a
// request / write / done handshake. The banks swap on the first visible pixel
// of every line. RGB and both syncs leave through one register stage, so the
// three outputs stay aligned.
//
// Ports
//   clk        pixel clock
//   rst        asynchronous, active-low reset
//   xp         pixel x from timing (ignored while visible = 0)
//   visible    active-video flag from timing
//   hsync_in   horizontal sync from timing
//   vsync_in   vertical sync from timing
//   fill_req   level: the back bank wants line fill_line
//   fill_line  index of the requested line
//   wr_en      renderer pixel write strobe (honoured only while filling)
//   wr_x       write address inside the back bank
//   wr_data    pixel value (2R 2G 2B)
//   fill_done  one-cycle pulse: the requested line is complete
//   rgb        registered pixel, 0 outside the visible area
//   hsync      hsync_in delayed one cycle
//   vsync      vsync_in delayed one cycle
//   underruns  saturating count of lines shown before their fill completed
//
// Build option
//   SCANLINE_UNDERRUN_CNT_EN  when defined, the underrun counter is built.
//                             Otherwise underruns is tied to 0.
// -----------------------------------------------------------------------------
module scanline_buffer #(
  parameter int LINE_W    = 256,
  parameter int COLOR_W   = 6,
  parameter int LINE_BITS = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           xp,
  input  logic                 visible,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  output logic                 fill_req,
  output logic [LINE_BITS-1:0] fill_line,
  input  logic                 wr_en,
  input  logic [7:0]           wr_x,
  input  logic [COLOR_W-1:0]   wr_data,
  input  logic                 fill_done,
  output logic [COLOR_W-1:0]   rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic [7:0]           underruns
);

  // Last visible line of a 480-line frame.
  localparam logic [LINE_BITS-1:0] LAST_LINE = LINE_BITS'(479);

  // ABORT is the single fill_req-low cycle that separates an abandoned fill
  // from the request for the next line.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_READY,
    S_ABORT
  } state_t;

  state_t               state, state_d;
  logic                 visible_q, vsync_q;
  logic                 front;
  logic                 vis_rise, vs_rise;
  logic                 line_avail, trigger, filling, rd_bank;
  logic [LINE_BITS-1:0] next_line;
  logic [COLOR_W-1:0]   ram [2][LINE_W];

  assign vis_rise   = visible & ~visible_q;
  assign vs_rise    = vsync_in & ~vsync_q;
  assign line_avail = (next_line <= LAST_LINE);
  assign trigger    = vs_rise | (vis_rise & line_avail);
  assign filling    = (state == S_REQ) || (state == S_FILL);
  assign fill_req   = filling;

  // On the swap cycle, the bank that was just filled is already the one shown.
  assign rd_bank = vis_rise ? ~front : front;

  // Edge-detect history, output pipeline and bank select.
  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      visible_q <= 1'b0;
      vsync_q   <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      rgb       <= '0;
      front     <= 1'b0;
    end else begin
      visible_q <= visible;
      vsync_q   <= vsync_in;
      hsync     <= hsync_in;
      vsync     <= vsync_in;
      rgb       <= visible ? ram[rd_bank][xp] : '0;
      if (vis_rise) front <= ~front;
    end
  end

  // Renderer writes always target the back bank. They are accepted only once
  // the request has been seen, i.e. in FILL.
  // NOTE: the RAM has no reset branch. Its contents are don't-care until the
  // first fill, and a reset would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (state == S_FILL && wr_en) ram[~front][wr_x] <= wr_data;
  end

  // next_line holds the line the next swap will request. A vsync requests
  // line 0 itself, so the first swap of a frame asks for line 1. Once line 479
  // has been requested, next_line parks at 480 and no further requests are
  // issued until the next vsync.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_line <= '0;
      fill_line <= '0;
    end else if (vs_rise) begin
      next_line <= LINE_BITS'(1);
      fill_line <= '0;
    end else if (vis_rise && line_avail) begin
      next_line <= next_line + LINE_BITS'(1);
      fill_line <= next_line;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  // NOTE: state_d gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_READY: if (trigger) state_d = S_REQ;
      S_REQ:           state_d = S_FILL;
      S_FILL:          if (fill_done) state_d = S_READY;
      S_ABORT:         state_d = S_REQ;
      default:         state_d = S_IDLE;
    endcase

    // A frame start or line swap overrides the handshake. If a swap lands
    // while a fill is still open, the partial line is shown as-is and the
    // request restarts after one idle cycle. fill_done in that cycle is lost.
    if (vs_rise) begin
      state_d = S_REQ;
    end else if (vis_rise) begin
      if (filling)         state_d = line_avail ? S_ABORT : S_IDLE;
      else if (line_avail) state_d = S_REQ;
      else                 state_d = S_IDLE;
    end
  end

`ifdef SCANLINE_UNDERRUN_CNT_EN
  logic [7:0] ur_cnt;
  logic       frame_had_ur;
  logic       underrun;

  assign underrun = vis_rise & ~vs_rise & filling;

  // The count is cleared at a frame start only if the frame just ended was
  // clean. A run of bad frames therefore keeps accumulating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ur_cnt       <= '0;
      frame_had_ur <= 1'b0;
    end else if (vs_rise) begin
      if (!frame_had_ur) ur_cnt <= '0;
      frame_had_ur <= 1'b0;
    end else if (underrun) begin
      frame_had_ur <= 1'b1;
      if (ur_cnt != 8'hFF) ur_cnt <= ur_cnt + 8'd1;
    end
  end

  assign underruns = ur_cnt;
`else
  assign underruns = '0;
`endif

endmodule

// File: tb/tb_scanline_buffer.sv
// -----------------------------------------------------------------------------
// tb_scanline_buffer
//
// Randomised bench for scanline_buffer. The stimulus side acts as both the
// timing generator and the renderer. Each cycle it pushes the expected
// {rgb, hsync, vsync} into a queue. A monitor pops one entry per clock and
// compares it with the outputs.
//
// The reference model is image-level: a "displayed" line and a "pending"
// line. Accepted renderer writes land in the pending line. At the first
// visible pixel of a line, the pending line becomes the displayed one.
// -----------------------------------------------------------------------------
module tb_scanline_buffer;

  localparam int LINE_W    = 256;
  localparam int COLOR_W   = 6;
  localparam int LINE_BITS = 9;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [7:0]           xp = '0;
  logic                 visible = 1'b0;
  logic                 hsync_in = 1'b0;
  logic                 vsync_in = 1'b0;
  logic                 fill_req;
  logic [LINE_BITS-1:0] fill_line;
  logic                 wr_en = 1'b0;
  logic [7:0]           wr_x = '0;
  logic [COLOR_W-1:0]   wr_data = '0;
  logic                 fill_done = 1'b0;
  logic [COLOR_W-1:0]   rgb;
  logic                 hsync;
  logic                 vsync;
  logic [7:0]           underruns;

  always #40 clk = ~clk;

  scanline_buffer #(
    .LINE_W   (LINE_W),
    .COLOR_W  (COLOR_W),
    .LINE_BITS(LINE_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .xp       (xp),
    .visible  (visible),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .fill_req (fill_req),
    .fill_line(fill_line),
    .wr_en    (wr_en),
    .wr_x     (wr_x),
    .wr_data  (wr_data),
    .fill_done(fill_done),
    .rgb      (rgb),
    .hsync    (hsync),
    .vsync    (vsync),
    .underruns(underruns)
  );

  typedef struct packed {
    logic [COLOR_W-1:0] rgb;
    logic               hs;
    logic               vs;
  } exp_t;

  int                 total = 0;
  int                 bad   = 0;
  exp_t               sb_q[$];
  logic [COLOR_W-1:0] disp_img [LINE_W];
  logic [COLOR_W-1:0] back_img [LINE_W];
  logic               m_vis_prev = 1'b0;
  logic               s_req;
  logic [LINE_BITS-1:0] s_line;
  int                 exp_line = 0;

  // Expected underrun count with the counter built in, or 0 when it is not.
  function automatic logic [31:0] ur_exp(input int n);
`ifdef SCANLINE_UNDERRUN_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one output triple per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rgb", 32'(rgb), 32'(e.rgb));
        check("hsync", 32'(hsync), 32'(e.hs));
        check("vsync", 32'(vsync), 32'(e.vs));
      end
    end
  end

  // One pixel clock of stimulus. s_req/s_line capture the handshake outputs
  // as they stand before these inputs take effect. 'lands' says whether the
  // renderer expects this write to be accepted.
  task automatic step(input logic v, input logic [7:0] x, input logic hs, input logic vs,
                      input logic we, input logic [7:0] wx, input logic [COLOR_W-1:0] wd,
                      input logic fd, input logic lands);
    exp_t               e;
    logic [COLOR_W-1:0] tmp;
    @(negedge clk);
    s_req     = fill_req;
    s_line    = fill_line;
    visible   = v;
    xp        = x;
    hsync_in  = hs;
    vsync_in  = vs;
    wr_en     = we;
    wr_x      = wx;
    wr_data   = wd;
    fill_done = fd;
    e.rgb = '0;
    e.hs  = hs;
    e.vs  = vs;
    if (v && !m_vis_prev) begin
      // First visible pixel: the pending line goes on screen now.
      e.rgb = back_img[x];
      if (we && lands) back_img[wx] = wd;
      for (int i = 0; i < LINE_W; i++) begin
        tmp         = disp_img[i];
        disp_img[i] = back_img[i];
        back_img[i] = tmp;
      end
    end else begin
      if (v) e.rgb = disp_img[x];
      if (we && lands) back_img[wx] = wd;
    end
    m_vis_prev = v;
    sb_q.push_back(e);
  endtask

  task automatic blank(input int n, input logic vs);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, rnd_bit(), vs, 1'b0, 8'd0, '0, 1'b0, 1'b0);
  endtask

  // Frame start: a vsync must raise a request for line 0 within two cycles.
  task automatic frame_start(input logic [31:0] exp_ur);
    bit got = 1'b0;
    blank(1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      blank(1, 1'b1);
      if (s_req && s_line == '0) got = 1'b1;
    end
    check("req_line0_after_vsync", 32'(got), 32'd1);
    exp_line = 0;
    blank(3, 1'b0);
    check("underruns_at_frame", 32'(underruns), exp_ur);
  endtask

  // Renderer: wait for the request, skip the REQ cycle, then write 'count'
  // pixels with random gaps. mode 0 writes x[5:0], 1 writes 0x15, 2 writes
  // 0x2A, 3 writes random data. With 'done', fill_done shares the cycle of
  // the last write.
  task automatic do_fill(input int mode, input int count, input bit done);
    int                 n = 0;
    logic [COLOR_W-1:0] d;
    do begin
      blank(1, 1'b0);
      n++;
    end while (!s_req && n < 40);
    check("fill_req_wait", 32'(s_req), 32'd1);
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 3) == 0) blank(1, 1'b0);
      case (mode)
        0:       d = COLOR_W'(i);
        1:       d = 6'h15;
        2:       d = 6'h2A;
        default: d = COLOR_W'($urandom);
      endcase
      step(1'b0, 8'd0, rnd_bit(), 1'b0, 1'b1, 8'(i), d, done && (i == count - 1), 1'b1);
    end
    if (done) begin
      blank(1, 1'b0);
      check("fill_req_after_done", 32'(s_req), 32'd0);
    end
  endtask

  // Visible line: xp runs 0..255. The bench checks the request that follows
  // the swap: it is immediate after a clean fill, or comes after one idle
  // cycle after an underrun.
  task automatic show_line(input bit underrun);
    for (int i = 0; i < LINE_W; i++) begin
      step(1'b1, 8'(i), rnd_bit(), 1'b0, 1'b0, 8'd0, '0, 1'b0, 1'b0);
      if (i == 1) begin
        if (underrun) begin
          check("abort_gap_req", 32'(s_req), 32'd0);
        end else begin
          check("req_after_swap", 32'(s_req), 32'd1);
          check("line_after_swap", 32'(s_line), 32'(exp_line + 1));
        end
      end
      if (i == 2 && underrun) begin
        check("req_after_abort", 32'(s_req), 32'd1);
        check("line_after_abort", 32'(s_line), 32'(exp_line + 1));
      end
    end
    exp_line++;
    blank(4, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < LINE_W; i++) begin
      disp_img[i] = '0;
      back_img[i] = '0;
    end

    // Reset state.
    #100;
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_fill_req", 32'(fill_req), 32'd0);
    check("rst_fill_line", 32'(fill_line), 32'd0);
    check("rst_underruns", 32'(underruns), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    blank(4, 1'b0);
    check("idle_no_req", 32'(s_req), 32'd0);

    // Frame 1: ramp line, alternating lines, an ignored write, an underrun.
    frame_start(ur_exp(0));
    do_fill(0, LINE_W, 1'b1);
    show_line(1'b0);
    do_fill(1, LINE_W, 1'b1);
    show_line(1'b0);
    do_fill(2, LINE_W, 1'b1);
    show_line(1'b0);
    do_fill(1, LINE_W, 1'b1);
    // The FSM is READY here, so this write must not reach pixel 5.
    step(1'b0, 8'd0, rnd_bit(), 1'b0, 1'b1, 8'd5, 6'h3F, 1'b0, 1'b0);
    show_line(1'b0);
    do_fill(3, LINE_W, 1'b1);
    show_line(1'b0);
    do_fill(3, 100, 1'b0);
    show_line(1'b1);
    check("underruns_after_underrun", 32'(underruns), ur_exp(1));
    do_fill(3, LINE_W, 1'b1);
    show_line(1'b0);

    // Frame 2 follows a frame with an underrun: the count holds.
    frame_start(ur_exp(1));
    do_fill(3, LINE_W, 1'b1);
    show_line(1'b0);

    // Frame 3 follows a clean frame: the count clears.
    frame_start(ur_exp(0));

    // Reset in the middle of a fill, between clock edges.
    do_fill(3, 50, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #4;
    check("pre_reset_hsync", 32'(hsync), 32'd1);
    check("pre_reset_fill_req", 32'(fill_req), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_fill_req", 32'(fill_req), 32'd0);
    check("async_rst_rgb", 32'(rgb), 32'd0);
    check("async_rst_hsync", 32'(hsync), 32'd0);
    check("async_rst_vsync", 32'(vsync), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_vis_prev = 1'b0;
    blank(3, 1'b0);
    check("post_reset_idle", 32'(s_req), 32'd0);
    frame_start(ur_exp(0));
    do_fill(3, LINE_W, 1'b1);
    show_line(1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
